ball_motion: RTL and testbench



---
 rtl/ball_motion.sv | 227 ++++++++++++++++++++++
 tb/tb_ball_motion.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Per-frame ball physics: advances the ball once per frame_tick, checks paddles and
// blocks one per cycle, clamps at the side walls and detects a missed ball.
module ball_motion #(
    parameter int BALL_R      = 10,
    parameter int STEP        = 2,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int WIDTH_user  = 100,
    parameter int HIGH_user   = 20,
    parameter int WIDTH_block = 100,
    parameter int HIGH_block  = 40,
    parameter int WALL_L      = 10,
    parameter int WALL_R      = 630,
    parameter int WALL_T      = 10,
    parameter int WALL_B      = 470
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] user1_xaddr,
    input  logic [9:0] user1_yaddr,
    input  logic [9:0] user2_xaddr,
    input  logic [9:0] user2_yaddr,
    input  logic [9:0] block1_xaddr,
    input  logic [9:0] block1_yaddr,
    input  logic [9:0] block2_xaddr,
    input  logic [9:0] block2_yaddr,
    input  logic [9:0] block3_xaddr,
    input  logic [9:0] block3_yaddr,
    output logic [9:0] ball_xaddr,
    output logic [9:0] ball_yaddr,
    output logic       game_over,
    output logic       busy,
    output logic [2:0] block_hit
);

    typedef logic signed [10:0] s11_t;

    typedef enum logic [3:0] {
        IDLE, WAIT, CALC, PAD1, PAD2, BLK1, BLK2, BLK3, WALL, COMMIT, OVER
    } state_t;

    localparam s11_t R_S      = 11'(BALL_R);
    localparam s11_t STEP_S   = 11'(STEP);
    localparam s11_t X_S      = 11'(X_INIT);
    localparam s11_t Y_S      = 11'(Y_INIT);
    localparam s11_t WALL_L_S = 11'(WALL_L);
    localparam s11_t WALL_R_S = 11'(WALL_R);
    localparam s11_t WALL_T_S = 11'(WALL_T);
    localparam s11_t WALL_B_S = 11'(WALL_B);
    localparam s11_t PAD_LX   = 11'(WIDTH_user / 2 + BALL_R);
    localparam s11_t PAD_LY   = 11'(HIGH_user / 2 + BALL_R);
    localparam s11_t BLK_LX   = 11'(WIDTH_block / 2 + BALL_R);
    localparam s11_t BLK_LY   = 11'(HIGH_block / 2 + BALL_R);

    function automatic s11_t abs11(input s11_t v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic s11_t zext(input logic [9:0] v);
        return $signed({1'b0, v});
    endfunction

    // Overlap on both axes, and only while the ball is heading toward the object.
    function automatic logic touches(input s11_t nx, input s11_t ny, input s11_t y,
                                     input s11_t cx, input s11_t cy,
                                     input s11_t lim_x, input s11_t lim_y,
                                     input logic dy_pos);
        logic toward;
        toward = dy_pos ? (cy > y) : (cy < y);
        return (abs11(nx - cx) <= lim_x) && (abs11(ny - cy) <= lim_y) && toward;
    endfunction

    state_t     state_q, state_d;
    s11_t       x_q, x_d, y_q, y_d;
    s11_t       nx_q, nx_d, ny_q, ny_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic       hit_q, hit_d;
    logic       busy_q, busy_d;
    logic       game_over_q, game_over_d;
    logic [2:0] block_hit_c;

    s11_t       obj_cx, obj_cy, obj_lx, obj_ly;
    logic [2:0] obj_mask;
    state_t     obj_next;
    logic       obj_hit;

    always_comb begin
        obj_cx   = '0;
        obj_cy   = '0;
        obj_lx   = '0;
        obj_ly   = '0;
        obj_mask = 3'b000;
        obj_next = WALL;
        case (state_q)
            PAD1: begin
                obj_cx = zext(user1_xaddr);  obj_cy = zext(user1_yaddr);
                obj_lx = PAD_LX;             obj_ly = PAD_LY;
                obj_next = PAD2;
            end
            PAD2: begin
                obj_cx = zext(user2_xaddr);  obj_cy = zext(user2_yaddr);
                obj_lx = PAD_LX;             obj_ly = PAD_LY;
                obj_next = BLK1;
            end
            BLK1: begin
                obj_cx = zext(block1_xaddr); obj_cy = zext(block1_yaddr);
                obj_lx = BLK_LX;             obj_ly = BLK_LY;
                obj_mask = 3'b001;           obj_next = BLK2;
            end
            BLK2: begin
                obj_cx = zext(block2_xaddr); obj_cy = zext(block2_yaddr);
                obj_lx = BLK_LX;             obj_ly = BLK_LY;
                obj_mask = 3'b010;           obj_next = BLK3;
            end
            BLK3: begin
                obj_cx = zext(block3_xaddr); obj_cy = zext(block3_yaddr);
                obj_lx = BLK_LX;             obj_ly = BLK_LY;
                obj_mask = 3'b100;           obj_next = WALL;
            end
            default: ;
        endcase
        obj_hit = touches(nx_q, ny_q, y_q, obj_cx, obj_cy, obj_lx, obj_ly, dy_q);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        hit_d       = hit_q;
        busy_d      = busy_q;
        game_over_d = game_over_q;
        block_hit_c = 3'b000;
        case (state_q)
            IDLE: if (start) state_d = WAIT;
            WAIT: if (frame_tick) begin
                state_d = CALC;
                busy_d  = 1'b1;
            end
            CALC: begin
                nx_d    = dx_q ? x_q + STEP_S : x_q - STEP_S;
                ny_d    = dy_q ? y_q + STEP_S : y_q - STEP_S;
                hit_d   = 1'b0;
                state_d = PAD1;
            end
            PAD1, PAD2, BLK1, BLK2, BLK3: begin
                // First object hit wins; the vertical move of that frame is cancelled.
                if (!hit_q && obj_hit) begin
                    dy_d        = ~dy_q;
                    ny_d        = y_q;
                    hit_d       = 1'b1;
                    block_hit_c = obj_mask;
                end
                state_d = obj_next;
            end
            WALL: begin
                if (nx_q - R_S <= WALL_L_S) begin
                    dx_d = 1'b1;
                    nx_d = WALL_L_S + R_S;
                end else if (nx_q + R_S >= WALL_R_S) begin
                    dx_d = 1'b0;
                    nx_d = WALL_R_S - R_S;
                end
                if (!hit_q && ((ny_q - R_S <= WALL_T_S) || (ny_q + R_S >= WALL_B_S))) begin
                    state_d     = OVER;
                    busy_d      = 1'b0;
                    game_over_d = 1'b1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                x_d     = nx_q;
                y_d     = ny_q;
                busy_d  = 1'b0;
                state_d = WAIT;
            end
            OVER: if (start) begin
                x_d         = X_S;
                y_d         = Y_S;
                dx_d        = 1'b1;
                dy_d        = 1'b1;
                game_over_d = 1'b0;
                state_d     = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= X_S;
            y_q         <= Y_S;
            nx_q        <= X_S;
            ny_q        <= Y_S;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_xaddr = x_q[9:0];
    assign ball_yaddr = y_q[9:0];
    assign busy       = busy_q;
    assign game_over  = game_over_q;
    assign block_hit  = rst ? 3'b000 : block_hit_c;

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion against a per-frame behavioural model of the
// ball rules (position, direction, first-hit reflection, wall clamp, miss).
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start;
    logic [9:0] ball_xaddr, ball_yaddr;
    logic       game_over, busy;
    logic [2:0] block_hit;

    // Object centres: 0 = user1, 1 = user2, 2..4 = block1..3
    int px[5];
    int py[5];

    int m_x, m_y, m_dx, m_dy;
    bit m_idle, m_over;
    int n_chk, n_fail;
    int max_y;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .user1_xaddr  (10'(px[0])),
        .user1_yaddr  (10'(py[0])),
        .user2_xaddr  (10'(px[1])),
        .user2_yaddr  (10'(py[1])),
        .block1_xaddr (10'(px[2])),
        .block1_yaddr (10'(py[2])),
        .block2_xaddr (10'(px[3])),
        .block2_yaddr (10'(py[3])),
        .block3_xaddr (10'(px[4])),
        .block3_yaddr (10'(py[4])),
        .ball_xaddr   (ball_xaddr),
        .ball_yaddr   (ball_yaddr),
        .game_over    (game_over),
        .busy         (busy),
        .block_hit    (block_hit)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        m_x = 320; m_y = 240; m_dx = 1; m_dy = 1;
        m_idle = 1; m_over = 0;
    endfunction

    // One frame of ball physics using plain integer arithmetic.
    function automatic void model_frame(output int hit_idx, output bit miss);
        int nx, ny, lx, ly;
        nx = m_x + 2 * m_dx;
        ny = m_y + 2 * m_dy;
        hit_idx = -1;
        miss = 0;
        for (int i = 0; i < 5; i++) begin
            lx = 50 + 10;
            ly = ((i < 2) ? 10 : 20) + 10;
            if (hit_idx < 0 && iabs(nx - px[i]) <= lx && iabs(ny - py[i]) <= ly &&
                ((m_dy > 0 && py[i] > m_y) || (m_dy < 0 && py[i] < m_y))) begin
                hit_idx = i;
                m_dy = -m_dy;
                ny = m_y;
            end
        end
        if (nx - 10 <= 10) begin
            m_dx = 1; nx = 20;
        end else if (nx + 10 >= 630) begin
            m_dx = -1; nx = 620;
        end
        if (hit_idx < 0 && (ny - 10 <= 10 || ny + 10 >= 470)) begin
            miss = 1;
            m_over = 1;
        end else begin
            m_x = nx;
            m_y = ny;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        cyc();
        rst = 1'b0;
        model_reset();
        chk("rst_x", ball_xaddr, 320);
        chk("rst_y", ball_yaddr, 240);
        chk("rst_busy", busy, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_block_hit", block_hit, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (m_over) begin
            m_x = 320; m_y = 240; m_dx = 1; m_dy = 1; m_over = 0;
        end
        m_idle = 0;
        chk("start_x", ball_xaddr, m_x);
        chk("start_y", ball_yaddr, m_y);
        chk("start_game_over", game_over, 0);
    endtask

    task automatic do_frame();
        int  hit_idx;
        bit  miss;
        bit  active;
        int  exp_bh;
        active = !m_idle && !m_over;
        hit_idx = -1;
        miss = 0;
        chk("busy_pre", busy, 0);
        if (active) model_frame(hit_idx, miss);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (active) begin
                if (c < 8 || !miss) chk("busy", busy, 1);
                exp_bh = (hit_idx >= 2 && c == hit_idx + 2) ? (1 << (hit_idx - 2)) : 0;
                chk("block_hit", block_hit, exp_bh);
                chk("game_over_mid", game_over, (miss && c == 8) ? 1 : 0);
                if (c == 3 && $urandom_range(0, 3) == 0) begin
                    frame_tick = 1'b1;
                    start = 1'($urandom_range(0, 1));
                end
            end else begin
                chk("busy_ignored", busy, 0);
            end
            cyc();
            frame_tick = 1'b0;
            start = 1'b0;
        end
        chk("ball_x", ball_xaddr, m_x);
        chk("ball_y", ball_yaddr, m_y);
        chk("busy_post", busy, 0);
        chk("game_over", game_over, m_over ? 1 : 0);
        if (int'(ball_yaddr) > max_y) max_y = int'(ball_yaddr);
    endtask

    task automatic park_all();
        px[0] = 900; py[0] = 30;
        px[1] = 900; py[1] = 450;
        for (int i = 2; i < 5; i++) begin
            px[i] = 900; py[i] = 900;
        end
    endtask

    function automatic int near(input int base, input int span);
        int v;
        v = base + int'($urandom_range(0, 2 * span)) - span;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        park_all();
        repeat (3) cyc();
        do_reset();

        // Idle: ticks without start do nothing
        repeat (3) do_frame();

        // Basic step
        do_start();
        do_frame();

        // Paddle bounce with both paddles tracking the ball
        do_reset();
        do_start();
        py[0] = 30;
        py[1] = 450;
        max_y = 0;
        for (int f = 0; f < 300 && !m_over; f++) begin
            px[0] = m_x;
            px[1] = m_x;
            do_frame();
        end
        chk("pad_max_y", max_y, 428);

        // Block bounce
        do_reset();
        park_all();
        px[2] = 340; py[2] = 300;
        do_start();
        repeat (16) do_frame();

        // Miss and restart
        do_reset();
        park_all();
        do_start();
        for (int f = 0; f < 150 && !m_over; f++) do_frame();
        chk("miss_reached", m_over ? 1 : 0, int'(game_over));
        repeat (2) do_frame();
        do_start();
        do_frame();

        // Reset in the middle of an update
        park_all();
        px[2] = m_x + 4; py[2] = m_y + 4;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        chk("midrst_x", ball_xaddr, 320);
        chk("midrst_y", ball_yaddr, 240);
        chk("midrst_busy", busy, 0);
        chk("midrst_block_hit", block_hit, 0);
        chk("midrst_game_over", game_over, 0);
        do_frame();

        // Randomized frames with objects scattered around the ball
        do_start();
        for (int f = 0; f < 250; f++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    px[i] = 900; py[i] = 900;
                end else begin
                    px[i] = near(m_x, 70);
                    py[i] = near(m_y, 45);
                end
            end
            repeat ($urandom_range(0, 3)) cyc();
            if (!m_over && $urandom_range(0, 7) == 0) do_start();
            do_frame();
            if (m_over) begin
                do_frame();
                do_start();
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
